dp_data_mem: RTL and testbench
==============================

# dp_data_mem

Parametrised dual-port, byte-addressed data memory for the pipelined CPU datapath. It replaces the fixed 128-byte combinational-read memory with configurable depth and width, per-byte write enables, a registered read pipeline with valid strobes, and defined write-collision arbitration. It also adds alignment and range checking and a post-reset hardware clear sequence. It sits behind the MEM stage: port A serves the load/store unit and port B serves the second pipe or the debug loader.

## Interface
- ADDR_W, 7, byte-address bits used; capacity 2^ADDR_W bytes
- DATA_W, 32, word width; a multiple of 8, with NB = DATA_W/8 byte lanes
- RD_LAT, 1, read latency in cycles (1..3)
- clk_i  in  1  clock; all state changes on its rising edge
- rst_i  in  1  synchronous reset, active-high
- busy_o  out  1  high while the clear sequence runs; requests are ignored
- pa_req_i / pb_req_i  in  1  request strobe, one transfer per cycle
- pa_we_i / pb_we_i  in  1  1 = write, 0 = read
- pa_be_i / pb_be_i  in  NB  byte enables for writes (lane 0 = bits 7:0); ignored for reads
- pa_addr_i / pb_addr_i  in  32  byte address
- pa_wdata_i / pb_wdata_i  in  DATA_W  write data
- pa_rdata_o / pb_rdata_o  out  DATA_W  read data, little-endian byte order
- pa_rvalid_o / pb_rvalid_o  out  1  one-cycle pulse when rdata is valid for a read
- pa_err_o / pb_err_o  out  1  one-cycle pulse when a request was rejected

## Operation
- Storage: 2^ADDR_W / NB words. Word index = addr[ADDR_W-1:log2(NB)].
- Clear FSM, two states:
  - CLEAR: entered on rst_i. A word pointer starts at 0 and one word is zeroed per cycle. busy_o=1. req inputs are ignored: no write, no rvalid, no err.
  - Transition to READY in the cycle after the last word is written.
  - READY: busy_o=0. Normal operation.
  - rst_i asserted in any state, including mid-clear, restarts CLEAR with the pointer at 0.
- Accepted request: req=1 while in READY.
- Address check: a request is rejected when addr[log2(NB)-1:0] ≠ 0 (misaligned) or addr ≥ 2^ADDR_W (out of range).
  - A rejected request writes nothing.
  - After RD_LAT cycles it pulses err=1. If it was a read, it also pulses rvalid=1 with rdata=0.
- Write: on the accept edge, update each byte lane whose be bit is 1. Other lanes keep their value. No rvalid for writes.
- Read: returns the whole word RD_LAT cycles after the accept edge.
- Read-during-write to the same word, either port in the same cycle: the read returns the old contents (read-first).
- Collision: both ports write the same word in the same cycle.
  - Lanes enabled on both ports take port B's data.
  - Lanes enabled on one port only take that port's data.
- rdata holds its last value until the next rvalid. Outputs do not change on non-valid cycles.

## Timing
- Reset values: busy_o=1, all rdata=0, all rvalid=0, all err=0. The read pipeline is flushed, so in-flight results are discarded.
- Clear duration: busy_o falls exactly 2^ADDR_W/NB cycles after the first cycle with rst_i=0. Default: 32 cycles.
- Read/err latency: a request accepted at edge N gives rvalid/err high during the cycle after edge N+RD_LAT-1.
  - RD_LAT=1: the result is registered on the accept edge itself.
  - Fully pipelined: one result per port per cycle, returned in request order.
- Writes are visible to reads accepted on the next edge or later.
- Ports are independent. Any combination of simultaneous operations is legal.

## Test plan
- Reset/clear:
  - Hold rst_i 2 cycles, release. Require busy_o=1 for exactly 32 cycles.
  - Then a read of 0x7C gives rdata=0x00000000 with rvalid after RD_LAT.
  - A request issued during busy gives no rvalid and no err.
- Byte enables:
  - A writes 0xEEF6F798 to 0x08 with be=1111.
  - Then A writes 0x0000AB00 to 0x08 with be=0010.
  - A read of 0x08 gives 0xEEF6AB98.
- Collision: in the same cycle, A writes 0x11111111 with be=1111 and B writes 0x22222222 with be=0011, both to 0x10. A subsequent read of 0x10 gives 0x11112222.
- Read-first:
  - 0x20 holds 0x00000005.
  - In the same cycle, A reads 0x20 and B writes 0x0000003F to 0x20.
  - A's read gives 0x00000005; the next read gives 0x0000003F.
- Errors:
  - Read of 0x0A: err=1, rvalid=1, rdata=0.
  - Write to 0x80: err=1, and every word is unchanged.
  - Repeat with RD_LAT=3 and check the latency is 3.
- Reset mid-operation:
  - Assert rst_i with reads in flight and while the clear is at word 10.
  - Require no rvalid from the flushed reads.
  - Require busy_o to stay high for a full 32 cycles after release.

Source files
------------

// File: rtl/dp_data_mem.sv
// Dual-port byte-addressed data memory with per-lane writes,
// registered read pipeline, address checking and post-reset clear.
module dp_data_mem #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic                busy_o,
  input  logic                pa_req_i,
  input  logic                pa_we_i,
  input  logic [DATA_W/8-1:0] pa_be_i,
  input  logic [31:0]         pa_addr_i,
  input  logic [DATA_W-1:0]   pa_wdata_i,
  output logic [DATA_W-1:0]   pa_rdata_o,
  output logic                pa_rvalid_o,
  output logic                pa_err_o,
  input  logic                pb_req_i,
  input  logic                pb_we_i,
  input  logic [DATA_W/8-1:0] pb_be_i,
  input  logic [31:0]         pb_addr_i,
  input  logic [DATA_W-1:0]   pb_wdata_i,
  output logic [DATA_W-1:0]   pb_rdata_o,
  output logic                pb_rvalid_o,
  output logic                pb_err_o
);

  localparam int NB     = DATA_W / 8;
  localparam int LOG_NB = $clog2(NB);
  localparam int WI_W   = ADDR_W - LOG_NB;
  localparam int DEPTH  = 1 << WI_W;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t          state_q, state_d;
  logic [WI_W-1:0] ptr_q, ptr_d;
  logic            clr_en;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic [1:0]        req, we;
  logic [NB-1:0]     be    [2];
  logic [31:0]       addr  [2];
  logic [DATA_W-1:0] wdata [2];

  logic [1:0]        acc, bad, wr_en, rd_en, er_en;
  logic [WI_W-1:0]   idx   [2];
  logic [DATA_W-1:0] rdat  [2];

  logic [RD_LAT-1:0] vld_q [2], vld_d [2];
  logic [RD_LAT-1:0] err_q [2], err_d [2];
  logic [DATA_W-1:0] dat_q [2][RD_LAT];
  logic [DATA_W-1:0] dat_d [2][RD_LAT];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == S_CLEAR) begin
      ptr_d = ptr_q + WI_W'(1);
      if (ptr_q == WI_W'(DEPTH - 1))
        state_d = S_READY;
    end
  end

  always_comb begin
    busy_o = (state_q == S_CLEAR);
    clr_en = busy_o & ~rst_i;
  end

  always_comb begin
    req      = {pb_req_i, pa_req_i};
    we       = {pb_we_i, pa_we_i};
    be[0]    = pa_be_i;
    be[1]    = pb_be_i;
    addr[0]  = pa_addr_i;
    addr[1]  = pb_addr_i;
    wdata[0] = pa_wdata_i;
    wdata[1] = pb_wdata_i;
  end

  always_comb begin
    acc   = '0;
    bad   = '0;
    wr_en = '0;
    rd_en = '0;
    er_en = '0;
    for (int p = 0; p < 2; p++) begin
      idx[p]   = addr[p][ADDR_W-1:LOG_NB];
      acc[p]   = req[p] & ~busy_o & ~rst_i;
      bad[p]   = ((addr[p] & 32'(NB - 1)) != '0) ||
                 ((addr[p] >> ADDR_W) != '0);
      wr_en[p] = acc[p] & we[p] & ~bad[p];
      rd_en[p] = acc[p] & ~we[p];
      er_en[p] = acc[p] & bad[p];
      rdat[p]  = bad[p] ? '0 : mem_q[idx[p]];
    end
  end

  // Port B is applied last so it owns lanes both ports enable
  always_comb begin
    mem_d = mem_q;
    if (clr_en)
      mem_d[ptr_q] = '0;
    for (int p = 0; p < 2; p++)
      for (int b = 0; b < NB; b++)
        if (wr_en[p] && be[p][b])
          mem_d[idx[p]][8*b +: 8] = wdata[p][8*b +: 8];
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_comb begin
    vld_d = vld_q;
    err_d = err_q;
    dat_d = dat_q;
    for (int p = 0; p < 2; p++) begin
      vld_d[p][0] = rd_en[p];
      err_d[p][0] = er_en[p];
      if (rd_en[p])
        dat_d[p][0] = rdat[p];
      for (int s = 1; s < RD_LAT; s++) begin
        vld_d[p][s] = vld_q[p][s-1];
        err_d[p][s] = err_q[p][s-1];
        if (vld_q[p][s-1])
          dat_d[p][s] = dat_q[p][s-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int p = 0; p < 2; p++) begin
        vld_q[p] <= '0;
        err_q[p] <= '0;
        for (int s = 0; s < RD_LAT; s++)
          dat_q[p][s] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      err_q <= err_d;
      dat_q <= dat_d;
    end
  end

  assign pa_rvalid_o = vld_q[0][RD_LAT-1];
  assign pa_err_o    = err_q[0][RD_LAT-1];
  assign pa_rdata_o  = dat_q[0][RD_LAT-1];
  assign pb_rvalid_o = vld_q[1][RD_LAT-1];
  assign pb_err_o    = err_q[1][RD_LAT-1];
  assign pb_rdata_o  = dat_q[1][RD_LAT-1];

endmodule

// File: tb/tb_dp_data_mem.sv
// Bench for dp_data_mem: RD_LAT=1 and RD_LAT=3 instances share
// stimulus and are checked against a byte-array reference model.
module tb_dp_data_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req  [2];
  logic        we   [2];
  logic [3:0]  be   [2];
  logic [31:0] addr [2];
  logic [31:0] wd   [2];

  logic        busy [2];
  logic        rv   [2][2];
  logic        er   [2][2];
  logic [31:0] rdo  [2][2];

  dp_data_mem #(.RD_LAT(1)) u_l1 (
    .clk_i(clk), .rst_i(rst), .busy_o(busy[0]),
    .pa_req_i(req[0]), .pa_we_i(we[0]), .pa_be_i(be[0]),
    .pa_addr_i(addr[0]), .pa_wdata_i(wd[0]),
    .pa_rdata_o(rdo[0][0]), .pa_rvalid_o(rv[0][0]),
    .pa_err_o(er[0][0]),
    .pb_req_i(req[1]), .pb_we_i(we[1]), .pb_be_i(be[1]),
    .pb_addr_i(addr[1]), .pb_wdata_i(wd[1]),
    .pb_rdata_o(rdo[0][1]), .pb_rvalid_o(rv[0][1]),
    .pb_err_o(er[0][1])
  );

  dp_data_mem #(.RD_LAT(3)) u_l3 (
    .clk_i(clk), .rst_i(rst), .busy_o(busy[1]),
    .pa_req_i(req[0]), .pa_we_i(we[0]), .pa_be_i(be[0]),
    .pa_addr_i(addr[0]), .pa_wdata_i(wd[0]),
    .pa_rdata_o(rdo[1][0]), .pa_rvalid_o(rv[1][0]),
    .pa_err_o(er[1][0]),
    .pb_req_i(req[1]), .pb_we_i(we[1]), .pb_be_i(be[1]),
    .pb_addr_i(addr[1]), .pb_wdata_i(wd[1]),
    .pb_rdata_o(rdo[1][1]), .pb_rvalid_o(rv[1][1]),
    .pb_err_o(er[1][1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int clr     = 0;
  int lat [2] = '{1, 3};

  logic [7:0]  mb   [128];
  logic        xv   [2][2][16];
  logic        xe   [2][2][16];
  logic [31:0] xd   [2][2][16];
  logic [31:0] held [2][2];

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at cycle %0d",
               tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mword(int a);
    return {mb[a+3], mb[a+2], mb[a+1], mb[a]};
  endfunction

  task automatic model_edge();
    bit busy_now;
    bit bad;
    int s;
    if (rst) begin
      foreach (mb[i]) mb[i] = 8'h00;
      clr = 32;
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) begin
          held[d][p] = 32'h0;
          for (int k = 0; k < 16; k++) begin
            xv[d][p][k] = 1'b0;
            xe[d][p][k] = 1'b0;
            xd[d][p][k] = 32'h0;
          end
        end
    end else begin
      busy_now = (clr > 0);
      for (int p = 0; p < 2; p++) begin
        bad = (addr[p][1:0] != 2'b00) || (addr[p] >= 32'd128);
        if (req[p] && !busy_now && (!we[p] || bad))
          for (int d = 0; d < 2; d++) begin
            s = (cyc + lat[d] - 1) % 16;
            xv[d][p][s] = !we[p];
            xe[d][p][s] = bad;
            xd[d][p][s] = (bad || we[p]) ? 32'h0
                                         : mword(int'(addr[p]));
          end
      end
      for (int p = 0; p < 2; p++) begin
        bad = (addr[p][1:0] != 2'b00) || (addr[p] >= 32'd128);
        if (req[p] && !busy_now && we[p] && !bad)
          for (int b = 0; b < 4; b++)
            if (be[p][b])
              mb[int'(addr[p]) + b] = wd[p][8*b +: 8];
      end
      if (clr > 0) clr--;
    end
  endtask

  task automatic compare();
    int s;
    s = cyc % 16;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("busy_l%0d", lat[d]), 32'(busy[d]),
          32'(clr > 0));
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("rvalid_l%0d_p%0d", lat[d], p),
            32'(rv[d][p]), 32'(xv[d][p][s]));
        chk($sformatf("err_l%0d_p%0d", lat[d], p),
            32'(er[d][p]), 32'(xe[d][p][s]));
        if (xv[d][p][s]) held[d][p] = xd[d][p][s];
        chk($sformatf("rdata_l%0d_p%0d", lat[d], p),
            rdo[d][p], held[d][p]);
        xv[d][p][s] = 1'b0;
        xe[d][p][s] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic op(int p, bit w, logic [31:0] a,
                    logic [31:0] d, logic [3:0] b);
    req[p]  = 1'b1;
    we[p]   = w;
    addr[p] = a;
    wd[p]   = d;
    be[p]   = b;
  endtask

  task automatic go(int n);
    repeat (n) begin
      step();
      req[0] = 1'b0;
      req[1] = 1'b0;
    end
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    go(n);
    rst = 1'b0;
  endtask

  task automatic clear_run();
    int n0, n1;
    n0 = int'(busy[0]);
    n1 = int'(busy[1]);
    repeat (35) begin
      if (clr > 0)
        for (int p = 0; p < 2; p++)
          if ($urandom_range(0, 1) == 1)
            op(p, 1'($urandom_range(0, 1)),
               32'($urandom_range(0, 140)), $urandom, 4'hF);
      go(1);
      n0 += int'(busy[0]);
      n1 += int'(busy[1]);
    end
    chk("busy_len_l1", 32'(n0), 32'd32);
    chk("busy_len_l3", 32'(n1), 32'd32);
  endtask

  task automatic read_all();
    for (int w = 0; w < 32; w++) begin
      op(0, 1'b0, 32'(w * 4), 32'h0, 4'h0);
      op(1, 1'b0, 32'((31 - w) * 4), 32'h0, 4'h0);
      go(1);
    end
    go(3);
  endtask

  initial begin
    int seen;
    logic [31:0] a;
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      req[p]  = 1'b0;
      we[p]   = 1'b0;
      be[p]   = 4'h0;
      addr[p] = 32'h0;
      wd[p]   = 32'h0;
    end
    @(negedge clk);
    do_reset(2);
    clear_run();

    op(0, 1'b0, 32'h7C, 32'h0, 4'h0);
    go(4);
    chk("clr_rd7c_l1", rdo[0][0], 32'h0);
    chk("clr_rd7c_l3", rdo[1][0], 32'h0);

    op(0, 1'b1, 32'h08, 32'hEEF6F798, 4'b1111);
    go(1);
    op(0, 1'b1, 32'h08, 32'h0000AB00, 4'b0010);
    go(1);
    op(0, 1'b0, 32'h08, 32'h0, 4'h0);
    go(4);
    chk("be_merge_l1", rdo[0][0], 32'hEEF6AB98);
    chk("be_merge_l3", rdo[1][0], 32'hEEF6AB98);

    op(0, 1'b1, 32'h10, 32'h11111111, 4'b1111);
    op(1, 1'b1, 32'h10, 32'h22222222, 4'b0011);
    go(1);
    op(1, 1'b0, 32'h10, 32'h0, 4'h0);
    go(4);
    chk("collide_l1", rdo[0][1], 32'h11112222);
    chk("collide_l3", rdo[1][1], 32'h11112222);

    op(0, 1'b1, 32'h20, 32'h5, 4'b1111);
    go(1);
    op(0, 1'b0, 32'h20, 32'h0, 4'h0);
    op(1, 1'b1, 32'h20, 32'h3F, 4'b1111);
    go(4);
    chk("rd_first_l1", rdo[0][0], 32'h5);
    chk("rd_first_l3", rdo[1][0], 32'h5);
    op(0, 1'b0, 32'h20, 32'h0, 4'h0);
    go(4);
    chk("rd_after_l1", rdo[0][0], 32'h3F);
    chk("rd_after_l3", rdo[1][0], 32'h3F);

    op(0, 1'b0, 32'h0A, 32'h0, 4'h0);
    go(1);
    chk("mis_err_l1", 32'(er[0][0]), 32'h1);
    chk("mis_rv_l1", 32'(rv[0][0]), 32'h1);
    seen = 0;
    for (int i = 2; i <= 5; i++) begin
      go(1);
      if (er[1][0] && seen == 0) seen = i;
    end
    chk("err_lat_l3", 32'(seen), 32'd3);
    chk("mis_rdata_l3", rdo[1][0], 32'h0);

    op(1, 1'b1, 32'h80, 32'hDEADBEEF, 4'b1111);
    go(1);
    chk("oor_werr_l1", 32'(er[0][1]), 32'h1);
    read_all();

    repeat (400) begin
      for (int p = 0; p < 2; p++)
        if ($urandom_range(0, 3) != 0) begin
          if ($urandom_range(0, 7) == 0)
            a = 32'($urandom_range(0, 255));
          else
            a = 32'($urandom_range(0, 31) * 4);
          op(p, 1'($urandom_range(0, 1)), a, $urandom,
             4'($urandom_range(0, 15)));
        end
      go(1);
    end
    read_all();

    op(0, 1'b0, 32'h04, 32'h0, 4'h0);
    op(1, 1'b0, 32'h08, 32'h0, 4'h0);
    go(1);
    op(0, 1'b0, 32'h0C, 32'h0, 4'h0);
    op(1, 1'b0, 32'h10, 32'h0, 4'h0);
    do_reset(1);
    go(10);
    do_reset(1);
    clear_run();
    read_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
